pe_row_psum_acc: RTL
====================

Name: pe_row_psum_acc

Overview:
- Downstream consumer of the 16-lane PE row. Accumulates each lane's signed 16-bit product over a multi-beat tile (kernel taps / input channels) into wide partial sums.
- On the tile's last beat it latches the sums into an output buffer with valid/ready handshake, plus an optional ReLU + arithmetic-shift + int8-saturated requantized copy for the next layer's pixel buffer.

Parameters:
- LANES, 16, number of PE lanes consumed in parallel
- IN_W, 16, signed product width per lane
- ACC_W, 24, signed accumulator / psum width per lane
- Q_W, 8, requantized output width, signed

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- product  input  LANES x IN_W  signed per-lane products from PE row
- in_valid  input  1  products valid this cycle
- in_first  input  1  first beat of tile; discard prior accumulation
- in_last  input  1  last beat of tile; emit result
- in_ready  output  1  block can accept a beat
- shamt  input  5  right-shift amount for requantization, sampled on last beat
- relu_en  input  1  clamp negatives to 0 before shift, sampled on last beat
- out_valid  output  1  output buffer holds a result
- out_ready  input  1  consumer accepts result
- out_psum  output  LANES x ACC_W  signed raw partial sums
- out_q  output  LANES x Q_W  signed requantized values
- out_ovf  output  1  some lane saturated during this tile

Behaviour:
- Beat accepted iff in_valid & in_ready. in_ready = !out_valid | out_ready, combinational, applies to every beat.
- FSM:
  - IDLE: no tile open, acc = 0. Accepted beat with !in_last -> ACCUM. Accepted beat with in_last -> stays IDLE and emits.
  - ACCUM: accepted beat with in_last -> IDLE and emits.
  - In IDLE, in_first is implied: acc is 0, so the result is identical.
- Per lane, on accept:
  - If in_first: next = sext(product).
  - Else: next = acc + sext(product), saturated to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Saturation event sets sticky tile_ovf. in_first clears tile_ovf before the OR.
- in_first mid-tile (ACCUM, no last seen): restarts the tile. Old sums and tile_ovf are discarded, no output is emitted.
- On accepted in_last:
  - out_psum <= next; out_ovf <= tile_ovf | this-beat saturation; out_valid <= 1.
  - acc <= 0, tile_ovf <= 0, state <= IDLE.
  - in_first & in_last on the same beat: out_psum = sext(product).
- Latency: last beat accepted in cycle t -> out_valid = 1 from cycle t+1.
- Requantize per lane, registered with out_psum on the same edge:
  - v = relu_en ? max(psum, 0) : psum.
  - s = v >>> shamt (arithmetic, floor).
  - out_q = clamp(s, -128, 127).
  - shamt >= ACC_W gives 0 or -1 per sign.
- Output hold: out_valid, out_psum, out_q, out_ovf stay stable while out_valid & !out_ready.
  - out_valid clears on out_ready unless a new last beat is accepted the same cycle; then it stays 1 and loads the new data (back-to-back, no bubble).
- in_valid low: no state change. product, in_first and in_last are ignored when not accepted.
- Reset (rst = 0, async), all values 0 and held while rst is low:
  - state = IDLE; acc = 0; tile_ovf = 0.
  - out_valid = 0, out_psum = 0, out_q = 0, out_ovf = 0.
- Reset mid-tile or with a pending output: the data is lost, no emission after release.
- in_ready is 1 after reset.

Test Plan:
- 3-beat tile, all lanes: products 100, -30, 7 (first on beat 0, last on beat 2), shamt = 2, relu_en = 0 -> one cycle after beat 2: out_valid = 1, out_psum = 77, out_q = 19, out_ovf = 0.
- Single beat with first & last, lane 0 = -300, relu_en = 1, shamt = 0 -> out_psum[0] = -300, out_q[0] = 0. Same with relu_en = 0 -> out_q[0] = -128.
- Saturation: 300 beats of product 32767 on lane 5 -> out_psum[5] = 8388607, out_ovf = 1. Next tile of product 1 -> out_ovf = 0.
- Backpressure: out_ready = 0 with a result pending -> in_ready = 0, beats ignored, outputs stable. Raise out_ready while a last beat is presented -> out_valid stays 1 with the new psum next cycle.
- Mid-tile restart: beats 50 (first), 50, then 9 with first & last -> out_psum = 9, exactly one output.
- Async reset asserted mid-tile between clock edges -> outputs zero immediately. Release, then run a 2-beat tile of 4, 4 -> out_psum = 8.

Source files
------------

// File: rtl/pe_row_psum_acc.sv
// Per-lane partial-sum accumulator behind the 16-lane PE row.
//
// Adds up each lane's signed product over a multi-beat tile. The tile's last
// beat moves the sums into a valid/ready output buffer together with a
// requantized copy: optional ReLU, arithmetic right shift, int8 clamp.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-low reset
//   product               LANES x IN_W signed products, lane i at [i*IN_W +: IN_W]
//   in_valid/in_ready     input beat handshake
//   in_first, in_last     tile delimiters, valid only on accepted beats
//   shamt, relu_en        requantization controls, sampled on the last beat
//   out_valid/out_ready   output buffer handshake
//   out_psum              LANES x ACC_W signed raw partial sums
//   out_q                 LANES x Q_W signed requantized values
//   out_ovf               some lane saturated during the emitted tile
module pe_row_psum_acc #(
    parameter int unsigned LANES = 16,
    parameter int unsigned IN_W  = 16,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned Q_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES*IN_W-1:0]  product,
    input  logic                   in_valid,
    input  logic                   in_first,
    input  logic                   in_last,
    output logic                   in_ready,
    input  logic [4:0]             shamt,
    input  logic                   relu_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*ACC_W-1:0] out_psum,
    output logic [LANES*Q_W-1:0]   out_q,
    output logic                   out_ovf
);

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e                 state_q;
    logic [LANES*ACC_W-1:0] acc_q;
    logic                   tile_ovf_q;

    logic [LANES*ACC_W-1:0] next_sum;
    logic [LANES*Q_W-1:0]   next_q;
    logic                   sat_any;
    logic                   tile_ovf_next;
    logic                   accept;
    logic                   restart;

    logic signed [ACC_W:0]   prod_x;
    logic signed [ACC_W:0]   base_x;
    logic signed [ACC_W:0]   sum_x;
    logic        [ACC_W-1:0] lane_sum;
    logic signed [ACC_W-1:0] relu_v;
    logic signed [ACC_W-1:0] shifted;
    logic        [Q_W-1:0]   lane_q;

    // A full output buffer only blocks input if the consumer is not draining it now.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // In idle the accumulator is already zero, so every beat there starts a tile.
    assign restart  = in_first || (state_q == StIdle);

    assign tile_ovf_next = (restart ? 1'b0 : tile_ovf_q) | sat_any;

    always_comb begin
        sat_any  = 1'b0;
        next_sum = '0;
        next_q   = '0;
        prod_x   = '0;
        base_x   = '0;
        sum_x    = '0;
        lane_sum = '0;
        relu_v   = '0;
        shifted  = '0;
        lane_q   = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            prod_x = {{(ACC_W + 1 - IN_W){product[i*IN_W + IN_W - 1]}},
                      product[i*IN_W +: IN_W]};
            base_x = restart ? '0 : {acc_q[i*ACC_W + ACC_W - 1], acc_q[i*ACC_W +: ACC_W]};
            sum_x  = base_x + prod_x;
            // One guard bit: the sum left the ACC_W range iff the top two bits differ.
            if (sum_x[ACC_W] != sum_x[ACC_W-1]) begin
                sat_any  = 1'b1;
                lane_sum = sum_x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                lane_sum = sum_x[ACC_W-1:0];
            end
            next_sum[i*ACC_W +: ACC_W] = lane_sum;

            relu_v  = (relu_en && lane_sum[ACC_W-1]) ? '0 : lane_sum;
            // Shifts past the width fill with the sign, giving 0 or -1.
            shifted = relu_v >>> shamt;
            // Fits in Q_W bits iff all bits from Q_W-1 upward are copies of the sign.
            if ((&shifted[ACC_W-1:Q_W-1]) || !(|shifted[ACC_W-1:Q_W-1])) begin
                lane_q = shifted[Q_W-1:0];
            end else begin
                lane_q = shifted[ACC_W-1] ? {1'b1, {(Q_W-1){1'b0}}}
                                          : {1'b0, {(Q_W-1){1'b1}}};
            end
            next_q[i*Q_W +: Q_W] = lane_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            tile_ovf_q <= 1'b0;
            out_valid  <= 1'b0;
            out_psum   <= '0;
            out_q      <= '0;
            out_ovf    <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (in_last) begin
                    // Overrides the drain above: back-to-back results keep out_valid high.
                    out_valid  <= 1'b1;
                    out_psum   <= next_sum;
                    out_q      <= next_q;
                    out_ovf    <= tile_ovf_next;
                    acc_q      <= '0;
                    tile_ovf_q <= 1'b0;
                    state_q    <= StIdle;
                end else begin
                    acc_q      <= next_sum;
                    tile_ovf_q <= tile_ovf_next;
                    state_q    <= StAccum;
                end
            end
        end
    end

endmodule
